decoder_rr_arbiter: RTL

- Round-robin arbiter that shares one downstream resource between 4 requesters.
- The granted index is expanded to a one-hot grant by the team's 2-to-4 decoder.
- Sits inside the TinyTapeout user tile:
  - req driven from ui_in[3:0];
  - grant mapped to uo_out[3:0];
  - grant_idx, grant_valid and timeout_pulse mapped to uo_out[7:4].
- Enforces fair rotation and a maximum hold time per grant.

---
 rtl/decoder_rr_arbiter_pkg.sv | 24 ++
 rtl/decoder_rr_arbiter_if.sv | 44 ++++
 rtl/decoder_rr_arbiter_dec2to4.sv | 23 ++
 rtl/decoder_rr_arbiter.sv | 117 +++++++++++
 4 files changed

// File: rtl/decoder_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared types and constants for the round-robin arbiter slice.
//   arb_state_e : two-state arbiter FSM encoding (IDLE, GRANT)
//   NUM_REQ     : number of requesters sharing the resource
//   IDX_W       : width of a requester index
//   next_idx()  : successor index with wrap-around, used for pointer rotation
// ----------------------------------------------------------------------------
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index of the requester after idx; wraps 3 -> 0 through natural overflow.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// decoder_rr_arbiter_if
// Request/grant bundle between the requesters and the arbiter.
//   ena           : tile enable (requester side -> arbiter)
//   req           : one request line per requester (requester side -> arbiter)
//   grant         : one-hot grant (arbiter -> requesters)
//   grant_idx     : index of the current or last granted requester
//   grant_valid   : high while a grant is held
//   timeout_pulse : one-cycle pulse on a forced release
//   busy          : arbiter is in its GRANT state
// Modports: master = requester side, slave = arbiter.
// ----------------------------------------------------------------------------
interface decoder_rr_arbiter_if;
    import arb_pkg::*;

    logic               ena;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               timeout_pulse;
    logic               busy;

    modport master (
        output ena,
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout_pulse,
        input  busy
    );

    modport slave (
        input  ena,
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout_pulse,
        output busy
    );

endinterface

// File: rtl/decoder_rr_arbiter_dec2to4.sv
// ----------------------------------------------------------------------------
// dec2to4
// Plain 2-to-4 one-hot decoder with enable.
//   sel_i : 2-bit select
//   en_i  : enable; when low the output is all zeros
//   y_o   : one-hot decode of sel_i, or 0
// ----------------------------------------------------------------------------
module dec2to4 (
    input  logic [1:0] sel_i,
    input  logic       en_i,
    output logic [3:0] y_o
);

    // Shift a single one into position; gating by en_i keeps the output quiet
    // whenever nothing is selected.
    always_comb begin
        y_o = 4'b0000;
        if (en_i) begin
            y_o = 4'b0001 << sel_i;
        end
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// ----------------------------------------------------------------------------
// decoder_rr_arbiter
// Round-robin arbiter sharing one resource among four requesters, with a
// maximum hold time per grant. The registered grant index is expanded to a
// one-hot grant through dec2to4, so the grant lines are glitch-free w.r.t. clk.
//   clk : system clock, rising-edge
//   rst : synchronous active-high reset
//   bus : decoder_rr_arbiter_if.slave (ena, req in; grant, grant_idx,
//         grant_valid, timeout_pulse, busy out)
// Parameters:
//   MAX_HOLD : maximum consecutive grant cycles; 0 disables the timeout
//   CNT_W    : hold counter width, 2**CNT_W must exceed MAX_HOLD
// ----------------------------------------------------------------------------
module decoder_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input logic                 clk,
    input logic                 rst,
    decoder_rr_arbiter_if.slave bus
);

    localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0] hold_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             tout_q;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;

    // Rotating priority scan: look at ptr, ptr+1, ptr+2, ptr+3 (mod 4) and
    // take the first requester that is asking. The index arithmetic wraps on
    // its own because cand is only IDX_W bits wide.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Arbiter FSM with all outputs registered. In GRANT the exit checks are
    // ordered: losing ena releases without moving the pointer, a dropped
    // request releases and rotates, and only a still-held request at the last
    // allowed cycle counts as a timeout. That ordering makes a request drop on
    // the threshold cycle a normal release with no pulse. Leaving GRANT always
    // passes through IDLE, which guarantees a zero-grant gap between grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            tout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ena && win_found) begin
                        idx_q   <= win_idx;
                        valid_q <= 1'b1;
                        hold_q  <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.ena) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end else if (!bus.req[idx_q]) begin
                        valid_q <= 1'b0;
                        ptr_q   <= next_idx(idx_q);
                        state_q <= IDLE;
                    end else if (TIMEOUT_EN && (hold_q == HOLD_LAST)) begin
                        valid_q <= 1'b0;
                        ptr_q   <= next_idx(idx_q);
                        tout_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + CNT_W'(1);
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    dec2to4 u_dec (
        .sel_i (idx_q),
        .en_i  (valid_q),
        .y_o   (bus.grant)
    );

    assign bus.grant_idx     = idx_q;
    assign bus.grant_valid   = valid_q;
    assign bus.timeout_pulse = tout_q;
    assign bus.busy          = valid_q;

endmodule
